// File: rtl/vga_sprite_compositor.sv
// Pixel compositor for the Dino Run VGA path: prioritised colour-keyed sprites,
// a BCD score readout from a font ROM, and frame-synchronous position commits.
module vga_sprite_compositor #(
  parameter int NUM_SPRITES = 8,
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int ROM_LATENCY = 1,
  parameter int NUM_DIGITS  = 3,
  parameter int DIGIT_W     = 5,
  parameter int DIGIT_H     = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      chipselect,
  input  logic                      write,
  input  logic [8:0]                address,
  input  logic [31:0]               writedata,
  input  logic [10:0]               hcount,
  input  logic [9:0]                vcount,
  input  logic                      blank_n,
  input  logic                      frame_start,
  output logic [NUM_SPRITES*10-1:0] spr_addr,
  input  logic [NUM_SPRITES*16-1:0] spr_data,
  output logic [9:0]                font_addr,
  input  logic                      font_data,
  output logic [4*NUM_DIGITS-1:0]   score_bcd,
  output logic [7:0]                vga_r,
  output logic [7:0]                vga_g,
  output logic [7:0]                vga_b
);

  localparam logic [8:0] ADDR_EN     = 9'd64;
  localparam logic [8:0] ADDR_SCORE  = 9'd65;
  localparam logic [8:0] ADDR_BG     = 9'd66;
  localparam logic [8:0] ADDR_KEY    = 9'd67;
  localparam logic [8:0] ADDR_SCOREX = 9'd68;
  localparam logic [8:0] ADDR_SCOREY = 9'd69;
  localparam logic [4*NUM_DIGITS-1:0] ALL_NINES = {NUM_DIGITS{4'd9}};

  logic                    wrEn;
  logic [9:0]              shadowX_q [NUM_SPRITES];
  logic [9:0]              shadowY_q [NUM_SPRITES];
  logic [9:0]              activeX_q [NUM_SPRITES];
  logic [9:0]              activeY_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]  shadowEn_q, activeEn_q;
  logic [15:0]             bg_q, key_q;
  logic [9:0]              scoreX_q, scoreY_q;
  logic [4*NUM_DIGITS-1:0] score_q, score_d, scoreBcd_q;
  logic                    carry;
  logic                    unusedBits;

  assign wrEn       = chipselect && write;
  assign unusedBits = ^{writedata[31:16], hcount[0]};

  // Shadow positions take writes at any time; the visible set only moves on frame_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        shadowX_q[k] <= '0;
        shadowY_q[k] <= '0;
        activeX_q[k] <= '0;
        activeY_q[k] <= '0;
      end
      shadowEn_q <= '0;
      activeEn_q <= '0;
      bg_q       <= 16'hFFFF;
      key_q      <= 16'hF81F;
      scoreX_q   <= 10'd8;
      scoreY_q   <= 10'd8;
    end else begin
      if (frame_start) begin
        for (int k = 0; k < NUM_SPRITES; k++) begin
          activeX_q[k] <= shadowX_q[k];
          activeY_q[k] <= shadowY_q[k];
        end
        activeEn_q <= shadowEn_q;
      end
      if (wrEn) begin
        for (int k = 0; k < NUM_SPRITES; k++) begin
          if (address == 9'(2*k))   shadowX_q[k] <= writedata[9:0];
          if (address == 9'(2*k+1)) shadowY_q[k] <= writedata[9:0];
        end
        case (address)
          ADDR_EN:     shadowEn_q <= writedata[NUM_SPRITES-1:0];
          ADDR_BG:     bg_q       <= writedata[15:0];
          ADDR_KEY:    key_q      <= writedata[15:0];
          ADDR_SCOREX: scoreX_q   <= writedata[9:0];
          ADDR_SCOREY: scoreY_q   <= writedata[9:0];
          default:     ;
        endcase
      end
    end
  end

  // Saturating BCD increment; clear takes precedence over +1.
  always_comb begin
    score_d = score_q;
    carry   = 1'b1;
    if (wrEn && address == ADDR_SCORE) begin
      if (writedata[1]) begin
        score_d = '0;
      end else if (writedata[0] && score_q != ALL_NINES) begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
          if (carry) begin
            if (score_q[4*d +: 4] == 4'd9) begin
              score_d[4*d +: 4] = 4'd0;
            end else begin
              score_d[4*d +: 4] = score_q[4*d +: 4] + 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q    <= '0;
      scoreBcd_q <= '0;
    end else begin
      score_q <= score_d;
      if (frame_start) scoreBcd_q <= score_q;
    end
  end

  assign score_bcd = scoreBcd_q;

  logic [10:0]              pixX, pixY, sprLeft, sprTop, digLeft, digTop;
  logic [NUM_SPRITES-1:0]   hit_d;
  logic [NUM_SPRITES*10-1:0] sprAddr_d;
  logic                     digitHit_d;
  logic [9:0]               fontAddr_d;
  logic [3:0]               glyph;

  assign pixX = {1'b0, hcount[10:1]};
  assign pixY = {1'b0, vcount};

  // 11-bit compares so sprites hanging off the right/bottom edge clip instead of wrapping.
  always_comb begin
    hit_d     = '0;
    sprAddr_d = '0;
    sprLeft   = '0;
    sprTop    = '0;
    for (int k = 0; k < NUM_SPRITES; k++) begin
      sprLeft = {1'b0, activeX_q[k]};
      sprTop  = {1'b0, activeY_q[k]};
      if (activeEn_q[k] && pixX >= sprLeft && pixX < sprLeft + 11'(SPRITE_W) &&
          pixY >= sprTop && pixY < sprTop + 11'(SPRITE_H)) begin
        hit_d[k] = 1'b1;
        sprAddr_d[10*k +: 10] = 10'((pixY - sprTop) * 11'(SPRITE_W) + (pixX - sprLeft));
      end
    end
  end

  always_comb begin
    digitHit_d = 1'b0;
    fontAddr_d = '0;
    digLeft    = '0;
    digTop     = {1'b0, scoreY_q};
    glyph      = '0;
    for (int p = 0; p < NUM_DIGITS; p++) begin
      digLeft = {1'b0, scoreX_q} + 11'(p * (DIGIT_W + 1));
      glyph   = scoreBcd_q[4*(NUM_DIGITS-1-p) +: 4];
      if (pixX >= digLeft && pixX < digLeft + 11'(DIGIT_W) &&
          pixY >= digTop && pixY < digTop + 11'(DIGIT_H)) begin
        digitHit_d = 1'b1;
        fontAddr_d = 10'(glyph) * 10'(DIGIT_W * DIGIT_H) +
                     10'((pixY - digTop) * 11'(DIGIT_W)) + 10'(pixX - digLeft);
      end
    end
  end

  logic [NUM_SPRITES*10-1:0] sprAddr_q;
  logic [9:0]                fontAddr_q;
  logic [NUM_SPRITES-1:0]    hitPipe_q [ROM_LATENCY];
  logic [ROM_LATENCY-1:0]    digitPipe_q, blankPipe_q;

  // The address register is the first of the ROM_LATENCY cycles, so flags ride alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sprAddr_q   <= '0;
      fontAddr_q  <= '0;
      digitPipe_q <= '0;
      blankPipe_q <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) hitPipe_q[i] <= '0;
    end else begin
      sprAddr_q      <= sprAddr_d;
      fontAddr_q     <= fontAddr_d;
      hitPipe_q[0]   <= hit_d;
      digitPipe_q[0] <= digitHit_d;
      blankPipe_q[0] <= blank_n;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        hitPipe_q[i]   <= hitPipe_q[i-1];
        digitPipe_q[i] <= digitPipe_q[i-1];
        blankPipe_q[i] <= blankPipe_q[i-1];
      end
    end
  end

  assign spr_addr  = sprAddr_q;
  assign font_addr = fontAddr_q;

  logic [15:0] pixel;
  logic [23:0] rgb_d, rgb_q;

  // Walk from lowest priority upward so sprite 0 wins; glyph ink and blanking override all.
  always_comb begin
    pixel = bg_q;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (hitPipe_q[ROM_LATENCY-1][k] && spr_data[16*k +: 16] != key_q)
        pixel = spr_data[16*k +: 16];
    end
    rgb_d = {pixel[15:11], 3'b000, pixel[10:5], 2'b00, pixel[4:0], 3'b000};
    if (digitPipe_q[ROM_LATENCY-1] && font_data) rgb_d = '0;
    if (!blankPipe_q[ROM_LATENCY-1]) rgb_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign vga_r = rgb_q[23:16];
  assign vga_g = rgb_q[15:8];
  assign vga_b = rgb_q[7:0];

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Self-checking bench for vga_sprite_compositor: constant vector table, hand sequences for
// double buffering / score / reset, and a randomized pixel stream against a pixel-rule model.
module tb_vga_sprite_compositor;

  localparam int NS  = 8;
  localparam int ND  = 3;
  localparam int LAT = 2;
  localparam logic [15:0] ROM_KEY = 16'hF81F;
  localparam logic [23:0] BG     = 24'hF8FCF8;
  localparam logic [23:0] GREEN  = 24'h00FC00;
  localparam logic [23:0] BLUE   = 24'h0000F8;
  localparam logic [23:0] RED    = 24'hF80000;
  localparam logic [23:0] BLACK  = 24'h000000;

  logic           clk = 1'b0;
  logic           reset, chipselect, write, blank_n, frame_start, font_data;
  logic [8:0]     address;
  logic [31:0]    writedata;
  logic [10:0]    hcount;
  logic [9:0]     vcount;
  logic [NS*10-1:0] spr_addr;
  logic [NS*16-1:0] spr_data;
  logic [9:0]     font_addr;
  logic [4*ND-1:0] score_bcd;
  logic [7:0]     vga_r, vga_g, vga_b;

  int testsRun = 0;
  int testsFailed = 0;

  vga_sprite_compositor #(
    .NUM_SPRITES(NS), .SPRITE_W(32), .SPRITE_H(32), .ROM_LATENCY(1),
    .NUM_DIGITS(ND), .DIGIT_W(5), .DIGIT_H(7)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .hcount(hcount), .vcount(vcount),
    .blank_n(blank_n), .frame_start(frame_start), .spr_addr(spr_addr),
    .spr_data(spr_data), .font_addr(font_addr), .font_data(font_data),
    .score_bcd(score_bcd), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  // ROM models: mode 0 gives each sprite a flat colour, mode 1 a hashed pattern with key holes.
  int          romMode = 0;
  logic [15:0] sprConst [NS];

  function automatic logic [15:0] romWord(int k, int a, int mode, logic [15:0] cst);
    if (mode == 0) return cst;
    if (a % 8 == 5) return ROM_KEY;
    return 16'((a * 977) ^ (k * 4951));
  endfunction

  always_comb begin
    spr_data = '0;
    for (int k = 0; k < NS; k++)
      spr_data[16*k +: 16] = romWord(k, int'(spr_addr[10*k +: 10]), romMode, sprConst[k]);
  end

  assign font_data = font_addr[0];

  // Model state: shadow/active sprite set, plain-integer score.
  int mShX[NS], mShY[NS], mX[NS], mY[NS];
  int mShEn, mEn, mBg, mKey, mSX, mSY, mScore, mShown;

  function automatic void modelReset();
    for (int k = 0; k < NS; k++) begin mShX[k] = 0; mShY[k] = 0; mX[k] = 0; mY[k] = 0; end
    mShEn = 0; mEn = 0; mBg = 16'hFFFF; mKey = 16'hF81F;
    mSX = 8; mSY = 8; mScore = 0; mShown = 0;
  endfunction

  function automatic void modelWrite(int a, int d);
    if (a < 2 * NS) begin
      if (a % 2 == 0) mShX[a/2] = d & 1023;
      else            mShY[a/2] = d & 1023;
    end else if (a == 64) mShEn = d & 255;
    else if (a == 65) begin
      if ((d & 2) != 0) mScore = 0;
      else if ((d & 1) != 0 && mScore < 999) mScore++;
    end
    else if (a == 66) mBg  = d & 16'hFFFF;
    else if (a == 67) mKey = d & 16'hFFFF;
    else if (a == 68) mSX  = d & 1023;
    else if (a == 69) mSY  = d & 1023;
  endfunction

  function automatic void modelCommit();
    for (int k = 0; k < NS; k++) begin mX[k] = mShX[k]; mY[k] = mShY[k]; end
    mEn = mShEn;
    mShown = mScore;
  endfunction

  function automatic logic [11:0] toBcd(int v);
    return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [23:0] expand(logic [15:0] c);
    return {c[15:11], 3'b000, c[10:5], 2'b00, c[4:0], 3'b000};
  endfunction

  function automatic logic [23:0] refPixel(int x, int y, bit blank);
    int left, val, a, div;
    logic [15:0] d;
    if (!blank) return BLACK;
    for (int p = 0; p < ND; p++) begin
      left = mSX + p * 6;
      if (x >= left && x < left + 5 && y >= mSY && y < mSY + 7) begin
        div = 1;
        for (int i = 0; i < ND - 1 - p; i++) div = div * 10;
        val = (mShown / div) % 10;
        a = val * 35 + (y - mSY) * 5 + (x - left);
        if (a % 2 == 1) return BLACK;
      end
    end
    for (int k = 0; k < NS; k++) begin
      if (((mEn >> k) & 1) == 1 && x >= mX[k] && x < mX[k] + 32 && y >= mY[k] && y < mY[k] + 32) begin
        a = (y - mY[k]) * 32 + (x - mX[k]);
        d = romWord(k, a, romMode, sprConst[k]);
        if (d != 16'(mKey)) return expand(d);
      end
    end
    return expand(16'(mBg));
  endfunction

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic writeReg(int a, int d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 9'(a); writedata = 32'(d);
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    modelWrite(a, d);
  endtask

  task automatic frameTick();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    modelCommit();
  endtask

  task automatic writeWithFrame(int a, int d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 9'(a); writedata = 32'(d); frame_start = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; frame_start = 1'b0;
    modelCommit();
    modelWrite(a, d);
  endtask

  // Hold one pixel on the counters and return the output once the pipeline has filled.
  task automatic applyStimulus(int x, int y, bit blank, output logic [23:0] rgb);
    @(negedge clk);
    hcount = 11'(x * 2 + int'($urandom % 2));
    vcount = 10'(y);
    blank_n = blank;
    repeat (LAT) @(posedge clk);
    #1;
    rgb = {vga_r, vga_g, vga_b};
  endtask

  typedef struct {
    int          x;
    int          y;
    bit          blank;
    logic [23:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [23:0] rgb;
  logic [23:0] expQ[$];
  logic [23:0] expPix;
  int          rx, ry;
  bit          rb;

  initial begin
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
    hcount = '0; vcount = '0; blank_n = 1'b0; frame_start = 1'b0;
    for (int k = 0; k < NS; k++) sprConst[k] = 16'h0000;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'(BLACK));
    checkOutput("reset_score", 32'(score_bcd), 32'h0);
    checkOutput("reset_spr_addr", 32'(spr_addr[31:0]), 32'h0);
    checkOutput("reset_font_addr", 32'(font_addr), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(50, 300, 1'b1, rgb);
    checkOutput("reset_bg_pixel", 32'(rgb), 32'(BG));
    applyStimulus(50, 300, 1'b0, rgb);
    checkOutput("reset_blank_pixel", 32'(rgb), 32'(BLACK));

    sprConst[0] = 16'hF81F; sprConst[1] = 16'h001F; sprConst[2] = 16'h07E0; sprConst[3] = 16'hF800;
    writeReg(0, 200); writeReg(1, 200);
    writeReg(2, 200); writeReg(3, 200);
    writeReg(4, 100); writeReg(5, 50);
    writeReg(6, 630); writeReg(7, 300);
    writeReg(64, 8'h0F);
    frameTick();

    vecs.push_back('{100, 50, 1'b1, GREEN, "spr2_topleft"});
    vecs.push_back('{131, 81, 1'b1, GREEN, "spr2_botright"});
    vecs.push_back('{132, 50, 1'b1, BG,    "spr2_past_right"});
    vecs.push_back('{99,  50, 1'b1, BG,    "spr2_before_left"});
    vecs.push_back('{100, 82, 1'b1, BG,    "spr2_past_bottom"});
    vecs.push_back('{100, 50, 1'b0, BLACK, "spr2_blanked"});
    vecs.push_back('{200, 200, 1'b1, BLUE, "key_falls_through"});
    vecs.push_back('{231, 231, 1'b1, BLUE, "overlap_corner"});
    vecs.push_back('{630, 300, 1'b1, RED,  "edge_col630"});
    vecs.push_back('{639, 300, 1'b1, RED,  "edge_col639"});
    vecs.push_back('{0,   300, 1'b1, BG,   "edge_no_wrap"});
    vecs.push_back('{9,   8,   1'b1, BLACK, "digit_ink"});
    vecs.push_back('{8,   8,   1'b1, BG,   "digit_paper"});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].blank, rgb);
      checkOutput(vecs[i].name, 32'(rgb), 32'(vecs[i].exp));
    end

    applyStimulus(105, 53, 1'b1, rgb);
    checkOutput("spr_addr_value", 32'(spr_addr[29:20]), 32'd101);
    checkOutput("spr_addr_miss", 32'(spr_addr[9:0]), 32'd0);
    applyStimulus(10, 9, 1'b1, rgb);
    checkOutput("font_addr_value", 32'(font_addr), 32'd7);

    sprConst[0] = 16'hF800;
    applyStimulus(200, 200, 1'b1, rgb);
    checkOutput("priority_spr0", 32'(rgb), 32'(RED));
    writeReg(67, 16'h07E0);
    applyStimulus(100, 50, 1'b1, rgb);
    checkOutput("key_write", 32'(rgb), 32'(BG));
    writeReg(67, 16'hF81F);

    writeReg(4, 300);
    applyStimulus(100, 50, 1'b1, rgb);
    checkOutput("shadow_old_kept", 32'(rgb), 32'(GREEN));
    applyStimulus(300, 50, 1'b1, rgb);
    checkOutput("shadow_new_hidden", 32'(rgb), 32'(BG));
    frameTick();
    applyStimulus(300, 50, 1'b1, rgb);
    checkOutput("commit_new", 32'(rgb), 32'(GREEN));
    applyStimulus(100, 50, 1'b1, rgb);
    checkOutput("commit_old_gone", 32'(rgb), 32'(BG));
    writeWithFrame(4, 400);
    applyStimulus(300, 50, 1'b1, rgb);
    checkOutput("coincident_old", 32'(rgb), 32'(GREEN));
    applyStimulus(400, 50, 1'b1, rgb);
    checkOutput("coincident_deferred", 32'(rgb), 32'(BG));
    frameTick();
    applyStimulus(400, 50, 1'b1, rgb);
    checkOutput("coincident_next", 32'(rgb), 32'(GREEN));

    writeReg(65, 2);
    for (int i = 0; i < 123; i++) writeReg(65, 1);
    checkOutput("score_not_committed", 32'(score_bcd), 32'h0);
    frameTick();
    checkOutput("score_123", 32'(score_bcd), 32'h123);
    for (int i = 0; i < 877; i++) writeReg(65, 1);
    frameTick();
    checkOutput("score_999", 32'(score_bcd), 32'(toBcd(mShown)));
    checkOutput("score_999_const", 32'(score_bcd), 32'h999);
    writeReg(65, 1);
    frameTick();
    checkOutput("score_saturate", 32'(score_bcd), 32'h999);
    applyStimulus(8, 8, 1'b1, rgb);
    checkOutput("glyph9_ink", 32'(rgb), 32'(BLACK));
    applyStimulus(9, 8, 1'b1, rgb);
    checkOutput("glyph9_paper", 32'(rgb), 32'(BG));
    applyStimulus(14, 8, 1'b1, rgb);
    checkOutput("glyph_digit1", 32'(rgb), 32'(BLACK));
    applyStimulus(13, 8, 1'b1, rgb);
    checkOutput("glyph_gap", 32'(rgb), 32'(BG));
    applyStimulus(20, 14, 1'b1, rgb);
    checkOutput("glyph_last_row", 32'(rgb), 32'(BLACK));
    writeReg(65, 3);
    frameTick();
    checkOutput("score_clear_wins", 32'(score_bcd), 32'h0);

    // Randomized stream: one pixel per clock, outputs compared LAT cycles later.
    romMode = 1;
    for (int k = 0; k < NS; k++) begin
      writeReg(2 * k, int'($urandom_range(0, 200)));
      writeReg(2 * k + 1, int'($urandom_range(0, 90)));
    end
    writeReg(64, int'($urandom % 256));
    writeReg(66, 16'h39E7);
    writeReg(68, int'($urandom_range(0, 60)));
    writeReg(69, int'($urandom_range(0, 40)));
    for (int i = 0; i < int'($urandom_range(0, 300)); i++) writeReg(65, 1);
    frameTick();
    expQ.delete();
    for (int n = 0; n < 1500 + LAT; n++) begin
      @(negedge clk);
      if (expQ.size() == LAT) begin
        expPix = expQ.pop_front();
        checkOutput("random_pixel", 32'({vga_r, vga_g, vga_b}), 32'(expPix));
      end
      rx = int'($urandom_range(0, 260));
      ry = int'($urandom_range(0, 140));
      rb = ($urandom % 8) != 0;
      hcount = 11'(rx * 2 + int'($urandom % 2));
      vcount = 10'(ry);
      blank_n = rb;
      expQ.push_back(refPixel(rx, ry, rb));
    end
    romMode = 0;

    applyStimulus(50, 300, 1'b1, rgb);
    checkOutput("pre_reset_bg", 32'(rgb), 32'(refPixel(50, 300, 1'b1)));
    #1;
    reset = 1'b1;
    #1;
    checkOutput("reset_async_black", 32'({vga_r, vga_g, vga_b}), 32'(BLACK));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("post_reset_black", 32'({vga_r, vga_g, vga_b}), 32'(BLACK));
    @(posedge clk);
    #1;
    checkOutput("post_reset_bg", 32'({vga_r, vga_g, vga_b}), 32'(BG));
    checkOutput("post_reset_score", 32'(score_bcd), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
